// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory access unit.
//   - SZ_* : request size encodings carried on req_size
//   - dmem_state_t : controller FSM states
//   - req_is_bad() : alignment / reserved-size check applied at accept
package dmem_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_WR,
        ST_RESP
    } dmem_state_t;

    // True when the request must be answered with an error and no RAM access.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_WORD: return (off != 2'b00);
            SZ_HALF: return off[0];
            SZ_BYTE: return 1'b0;
            SZ_RSVD: return 1'b1;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane: combinational little-endian lane logic.
//   size, sign_ext, offset : captured request attributes
//   rdata      : word read from RAM
//   wdata      : store data (byte/half taken from the low bits)
//   load_data  : selected lane, sign- or zero-extended to 32 bits
//   merge_data : rdata with the store lane replaced by wdata (word size: wdata)
module dmem_lane
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{offset, 3'b000} +: 8];
        half_sel   = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data  = rdata;
        merge_data = wdata;
        case (size)
            SZ_BYTE: begin
                load_data  = {{24{sign_ext & byte_sel[7]}}, byte_sel};
                merge_data = rdata;
                merge_data[{offset, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                // Alignment was checked at accept, so only offset[1] matters.
                load_data  = {{16{sign_ext & half_sel[15]}}, half_sel};
                merge_data = rdata;
                if (offset[1]) merge_data[31:16] = wdata[15:0];
                else           merge_data[15:0]  = wdata[15:0];
            end
            default: begin
                load_data  = rdata;
                merge_data = wdata;
            end
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: single-outstanding load/store unit in front of a word-wide
// synchronous RAM (1-cycle read latency). Sub-word stores use read-modify-write.
//   clk, rst (async, active-low)
//   req_*      : CPU request (valid/ready handshake, accepted in IDLE only)
//   resp_*     : one-cycle completion pulse, error flag, held load data
//   ram_*      : RAM port; driven only from FSM state and captured registers
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    dmem_state_t state, state_nxt;

    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              err_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;

    logic [31:0] lane_load;
    logic [31:0] lane_merge;
    logic        accept;
    logic        bad_req;

    // Address bits above the RAM size wrap by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    assign accept  = (state == ST_IDLE) && req_valid;
    assign bad_req = req_is_bad(req_size, req_addr[1:0]);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (bad_req)                            state_nxt = ST_RESP;
                    else if (req_we && req_size == SZ_WORD) state_nxt = ST_WR;
                    else                                    state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                ram_en    = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                state_nxt = we_q ? ST_WR : ST_RESP;
            end
            ST_WR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: the data registers (not a memory array) are reset so that outputs
    // derived from them read 0 after reset and an abandoned RMW leaves nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            size_q   <= SZ_WORD;
            signed_q <= 1'b0;
            off_q    <= 2'b00;
            waddr_q  <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            merge_q  <= '0;
            rdata_q  <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                off_q    <= req_addr[1:0];
                waddr_q  <= req_addr[ADDR_W+1:2];
                wdata_q  <= req_wdata;
                err_q    <= bad_req;
            end
            // ram_rdata is valid in WAIT; loads update the held result,
            // sub-word stores build the word to write back.
            if (state == ST_WAIT) begin
                if (we_q) merge_q <= lane_merge;
                else      rdata_q <= lane_load;
            end
        end
    end

    dmem_lane u_lane (
        .size       (size_q),
        .sign_ext   (signed_q),
        .offset     (off_q),
        .rdata      (ram_rdata),
        .wdata      (wdata_q),
        .load_data  (lane_load),
        .merge_data (lane_merge)
    );

    assign ram_addr   = waddr_q;
    assign ram_wdata  = (size_q == SZ_WORD) ? wdata_q : merge_q;
    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed, table-driven bench for dmem_ctrl with a behavioural RAM.
module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int ADDR_W = 11;
    localparam int MAXLAT = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_we, req_signed;
    logic [1:0]        req_size;
    logic [31:0]       req_addr, req_wdata;
    logic              req_ready, resp_valid, resp_err;
    logic [31:0]       resp_rdata;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata, ram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural synchronous RAM with access counters.
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    int          n_rd = 0;
    int          n_wr = 0;
    int          last_addr = -1;

    always @(posedge clk) begin
        if (ram_en) begin
            last_addr <= int'(ram_addr);
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                n_wr          <= n_wr + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
                n_rd      <= n_rd + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called right after the accepting edge; returns cycles until resp_valid.
    task automatic wait_resp(output int lat);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < MAXLAT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          nrd;
        int          nwr;
        int          waddr;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int lat, input logic err, input logic [31:0] rdata,
                                input int nrd, input int nwr, input int waddr);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.err = err; v.rdata = rdata;
        v.nrd = nrd; v.nwr = nwr; v.waddr = waddr;
        return v;
    endfunction

    vec_t vecs[21];

    initial begin
        int          lat, c, first_resp, ready_c, rd0, wr0;
        logic [31:0] got;

        //               we size     sg addr          wdata         lat err rdata        rd wr word
        vecs[0]  = mk(1, SZ_WORD, 0, 32'h0000_0010, 32'hDEAD_BEEF, 2, 0, 32'h0000_0000, 0, 1, 4);
        vecs[1]  = mk(0, SZ_WORD, 0, 32'h0000_0010, 32'h0,         3, 0, 32'hDEAD_BEEF, 1, 0, 4);
        vecs[2]  = mk(1, SZ_WORD, 0, 32'h0000_0010, 32'h1122_3344, 2, 0, 32'hDEAD_BEEF, 0, 1, 4);
        vecs[3]  = mk(1, SZ_BYTE, 0, 32'h0000_0011, 32'hFFFF_FFAB, 4, 0, 32'hDEAD_BEEF, 1, 1, 4);
        vecs[4]  = mk(0, SZ_WORD, 0, 32'h0000_0010, 32'h0,         3, 0, 32'h1122_AB44, 1, 0, 4);
        vecs[5]  = mk(1, SZ_WORD, 0, 32'h0000_0010, 32'h8000_F080, 2, 0, 32'h1122_AB44, 0, 1, 4);
        vecs[6]  = mk(0, SZ_BYTE, 1, 32'h0000_0010, 32'h0,         3, 0, 32'hFFFF_FF80, 1, 0, 4);
        vecs[7]  = mk(0, SZ_BYTE, 0, 32'h0000_0010, 32'h0,         3, 0, 32'h0000_0080, 1, 0, 4);
        vecs[8]  = mk(0, SZ_HALF, 1, 32'h0000_0012, 32'h0,         3, 0, 32'hFFFF_8000, 1, 0, 4);
        vecs[9]  = mk(0, SZ_HALF, 0, 32'h0000_0012, 32'h0,         3, 0, 32'h0000_8000, 1, 0, 4);
        vecs[10] = mk(0, SZ_WORD, 0, 32'h0000_0012, 32'h0,         1, 1, 32'h0000_8000, 0, 0, 0);
        vecs[11] = mk(1, SZ_HALF, 0, 32'h0000_0013, 32'h0000_1234, 1, 1, 32'h0000_8000, 0, 0, 0);
        vecs[12] = mk(0, SZ_RSVD, 0, 32'h0000_0010, 32'h0,         1, 1, 32'h0000_8000, 0, 0, 0);
        vecs[13] = mk(1, SZ_HALF, 0, 32'h0000_0016, 32'h5555_CAFE, 4, 0, 32'h0000_8000, 1, 1, 5);
        vecs[14] = mk(0, SZ_BYTE, 1, 32'h0000_0017, 32'h0,         3, 0, 32'hFFFF_FFCA, 1, 0, 5);
        vecs[15] = mk(0, SZ_WORD, 0, 32'h0000_2014, 32'h0,         3, 0, 32'hCAFE_0000, 1, 0, 5);
        vecs[16] = mk(1, SZ_BYTE, 0, 32'h0000_0016, 32'h0000_0077, 4, 0, 32'hCAFE_0000, 1, 1, 5);
        vecs[17] = mk(0, SZ_HALF, 0, 32'h0000_0016, 32'h0,         3, 0, 32'h0000_CA77, 1, 0, 5);
        vecs[18] = mk(0, SZ_HALF, 1, 32'h0000_0014, 32'h0,         3, 0, 32'h0000_0000, 1, 0, 5);
        vecs[19] = mk(1, SZ_BYTE, 0, 32'h0000_0004, 32'h1234_565A, 4, 0, 32'h0000_0000, 1, 1, 1);
        vecs[20] = mk(0, SZ_BYTE, 1, 32'h0000_0004, 32'h0,         3, 0, 32'h0000_005A, 1, 0, 1);

        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        ram_rdata = '0;
        rst = 1'b0;
        drive(0, SZ_WORD, 0, 32'h0, 32'h0);
        req_valid = 1'b0;
        #1;
        check("reset req_ready",  {31'b0, req_ready},  32'h1);
        check("reset resp_valid", {31'b0, resp_valid}, 32'h0);
        check("reset resp_err",   {31'b0, resp_err},   32'h0);
        check("reset ram_en",     {31'b0, ram_en},     32'h0);
        check("reset ram_we",     {31'b0, ram_we},     32'h0);
        check("reset ram_addr",   32'(ram_addr),       32'h0);
        check("reset ram_wdata",  ram_wdata,           32'h0);
        check("reset resp_rdata", resp_rdata,          32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            check($sformatf("v%0d ready", i), {31'b0, req_ready}, 32'h1);
            rd0 = n_rd;
            wr0 = n_wr;
            drive(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata);
            @(posedge clk);
            wait_resp(lat);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d err", i), {31'b0, resp_err}, {31'b0, vecs[i].err});
            check($sformatf("v%0d rdata", i), resp_rdata, vecs[i].rdata);
            check($sformatf("v%0d reads", i), 32'(n_rd - rd0), 32'(vecs[i].nrd));
            check($sformatf("v%0d writes", i), 32'(n_wr - wr0), 32'(vecs[i].nwr));
            if (vecs[i].nrd + vecs[i].nwr > 0)
                check($sformatf("v%0d word addr", i), 32'(last_addr), 32'(vecs[i].waddr));
        end

        // Reset during WAIT of a byte store: no write, outputs clear at once.
        @(negedge clk);
        wr0 = n_wr;
        drive(1, SZ_BYTE, 0, 32'h0000_0010, 32'h0000_0011);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rmw reset ram_en",     {31'b0, ram_en},     32'h0);
        check("rmw reset ram_we",     {31'b0, ram_we},     32'h0);
        check("rmw reset resp_valid", {31'b0, resp_valid}, 32'h0);
        check("rmw reset req_ready",  {31'b0, req_ready},  32'h1);
        check("rmw reset resp_rdata", resp_rdata,          32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("rmw reset no write", 32'(n_wr - wr0), 32'h0);
        @(negedge clk);
        check("post reset ready", {31'b0, req_ready}, 32'h1);
        drive(0, SZ_WORD, 0, 32'h0000_0010, 32'h0);
        @(posedge clk);
        wait_resp(lat);
        check("post reset lw latency", 32'(lat), 32'd3);
        check("post reset lw data", resp_rdata, 32'h8000_F080);

        // Handshake: second request held while busy is taken only after RESP.
        @(negedge clk);
        wr0 = n_wr;
        drive(0, SZ_WORD, 0, 32'h0000_0010, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1, SZ_WORD, 0, 32'h0000_0018, 32'h1234_5678);
        c = 1;
        first_resp = 0;
        ready_c = 0;
        got = '0;
        while (c < MAXLAT) begin
            if (resp_valid && first_resp == 0) begin
                first_resp = c;
                got = resp_rdata;
            end
            if (req_ready) begin
                ready_c = c;
                break;
            end
            @(negedge clk);
            c++;
        end
        check("hs first resp cycle", 32'(first_resp), 32'd3);
        check("hs first resp data", got, 32'h8000_F080);
        check("hs ready cycle", 32'(ready_c), 32'd4);
        check("hs no early write", 32'(n_wr - wr0), 32'h0);
        @(posedge clk);
        wait_resp(lat);
        check("hs second latency", 32'(lat), 32'd2);
        check("hs second write", 32'(n_wr - wr0), 32'h1);
        check("hs second addr", 32'(last_addr), 32'd6);
        @(negedge clk);
        drive(0, SZ_WORD, 0, 32'h0000_0018, 32'h0);
        @(posedge clk);
        wait_resp(lat);
        check("hs readback", resp_rdata, 32'h1234_5678);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory access unit sitting directly downstream of the multi-cycle CPU core's memory port. It accepts one load/store request at a time and drives a word-wide synchronous RAM with 1-cycle read latency. Byte and halfword stores (`sb`/`sh`) are done by read-modify-write. Loads (`lb`/`lbu`/`lh`/`lhu`/`lw`) return lane-extracted, sign- or zero-extended data, and misaligned accesses are rejected with an error response.

## Interface
- `ADDR_W`, 11, RAM word-address width (2^ADDR_W words)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  request present; held by the CPU until accepted
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 word, 01 half, 10 byte, 11 reserved
- `req_signed`  in  1  loads only: 1 sign-extend, 0 zero-extend
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data; byte/half taken from the low bits
- `req_ready`  out  1  high only in IDLE; the request is accepted when `req_valid && req_ready`
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load result; holds its value until the next load completes
- `resp_err`  out  1  qualified by `resp_valid`: misaligned or reserved size
- `ram_en`  out  1  RAM access enable
- `ram_we`  out  1  RAM write enable (only with `ram_en`)
- `ram_addr`  out  ADDR_W  word address = `req_addr[ADDR_W+1:2]`
- `ram_wdata`  out  32  full word to write
- `ram_rdata`  in  32  RAM read data, valid the cycle after `ram_en && !ram_we`

## Operation
- On accept, capture `we`, `size`, `signed`, `addr`, `wdata` into internal registers. All RAM outputs are driven from state plus the captured registers only.
- **Alignment check at accept:**
  - Half requires `addr[0]==0`; word requires `addr[1:0]==0`.
  - `size==11` is an error.
  - An error skips all RAM activity.
- **Lane mapping** is little-endian:
  - Byte offset k occupies bits `[8k+7:8k]`.
  - Half at offset 0 occupies `[15:0]`; half at offset 2 occupies `[31:16]`.
- **FSM states:** IDLE, RD, WAIT, WR, RESP.
  - IDLE → RESP with `err=1` for an error request.
  - IDLE → WR for a word store.
  - IDLE → RD for a load or a sub-word store.
  - RD: `ram_en=1`, `ram_we=0`. Always → WAIT.
  - WAIT, load: extract the lane, extend it to 32 bits, register it into `resp_rdata`, then → RESP.
  - WAIT, sub-word store: merge the store lane into `ram_rdata` in a merge register, then → WR.
  - WR: `ram_en=1`, `ram_we=1`. `ram_wdata` is the captured word (word store) or the merge register (sub-word store). → RESP.
  - RESP: `resp_valid=1`; `resp_err` is set only for error requests. → IDLE.
- Stores and errors leave `resp_rdata` unchanged.
- Address bits above `ADDR_W+1` are ignored, so addresses wrap modulo the RAM size.

## Timing
- Request accepted at cycle N (IDLE, `req_valid=1`). Response pulse timing by type:
  - error: N+1
  - word store: N+2
  - load: N+3
  - sub-word store: N+4
- `req_ready` falls the cycle after accept and rises again the cycle after RESP. Back-to-back throughput is therefore one request per (latency+1) cycles.
- `req_valid` while `req_ready=0` is ignored. No internal queueing.
- The RAM write commits at the rising edge ending the WR cycle. The RMW read and write target the same word, with no intervening access.
- **Reset** (asynchronous, mid-operation included):
  - state → IDLE
  - captured registers, merge register and `resp_rdata` → 0
  - `ram_en`, `ram_we`, `resp_valid`, `resp_err` → 0 immediately
  - `req_ready` → 1
  - an in-flight RMW is abandoned with no write.
- All outputs after reset: 0, except `req_ready=1`.

## Structure
- `dmem_pkg` holds:
  - size encodings `SZ_WORD`, `SZ_HALF`, `SZ_BYTE`, `SZ_RSVD`
  - the FSM state enum `dmem_state_t`.
- Sub-module `dmem_lane` (combinational) does lane extract+extend for loads and lane merge for stores. It is instantiated once and shared; the FSM, registers and handshake stay in `dmem_ctrl`.

## Test plan
- **Word store then load.** Store 0xDEADBEEF at 0x10, then `lw` 0x10.
  - Store: `resp_valid` at N+2, with `ram_we` seen once at word 4.
  - Load: `resp_rdata`=0xDEADBEEF at N+3.
- **Byte store RMW.** Word 4 = 0x11223344; `sb` 0xAB at 0x11; `lw` 0x10.
  - Exactly one read and one write occur.
  - Result 0x1122AB44; store response at N+4.
- **Signed/unsigned loads.** Word 4 = 0x8000F080.
  - `lb` 0x10 → 0xFFFFFF80; `lbu` 0x10 → 0x00000080.
  - `lh` 0x12 → 0xFFFF8000; `lhu` 0x12 → 0x00008000.
- **Misaligned.**
  - `lw` 0x12 → `resp_err=1` at N+1, no `ram_en`.
  - `sh` 0x13 → `resp_err=1` at N+1, no `ram_en`.
  - `size`=11 → `resp_err=1` at N+1, no `ram_en`.
  - `resp_rdata` unchanged in all three cases.
- **Reset mid-RMW.** Assert `rst=0` in WAIT of an `sb`.
  - Outputs are cleared asynchronously; `req_ready=1` after release.
  - A following `lw` shows the original word unchanged.
- **Handshake.** Hold `req_valid` with new data while busy.
  - The second request is accepted only in the cycle after RESP and completes with correct data.
